// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the pipeline stages.
// Holds icode/ifun/stat constants, the register-none code and the M-register record.
// Pure declarations; no logic, no state.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes (ifun of OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  // Condition codes (ifun of cmovXX / jXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Pipeline status
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Flags after reset: ZF set, SF/OF clear ({ZF,SF,OF})
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  // Contents of the M register when a nop bubble is inserted
  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                  val_e: 64'd0, val_a: 64'd0,
                                  dst_e: RNONE, dst_m: RNONE};

  // A later stage holding one of these blocks the flag update
  function automatic logic stat_is_exc(input logic [2:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: E-register inputs, downstream status, forwarding and M-register outputs.
// Pure wiring; timing is owned by the execute stage itself.
// No backpressure signals; stalls are expressed by the producer through M_bubble.
interface execute_stage_if;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic        M_bubble;

  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;

  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_dstE, e_Cnd,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_dstE, e_Cnd,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );
endinterface

// File: rtl/y86_alu.sv
// y86_alu: 64-bit ALU with ZF/SF/OF generation; mulq only when EXECUTE_MUL_EN is defined.
// Purely combinational, zero latency.
// No backpressure; fn_ok=0 flags an unsupported function (result forced to 0).
module y86_alu
  import y86_pkg::*;
(
  input  logic [3:0]  alu_fn,
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        fn_ok
);

  // Compute result and signed overflow; operands are ordered aluB op aluA
  always_comb begin
    result = 64'd0;
    of     = 1'b0;
    fn_ok  = 1'b1;
    case (alu_fn)
      ALU_ADD: begin
        result = alu_b + alu_a;
        of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        of     = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
`ifdef EXECUTE_MUL_EN
      ALU_MUL: result = alu_b * alu_a;
`endif
      default: fn_ok = 1'b0;
    endcase
  end

  assign zf = (result == 64'd0);
  assign sf = result[63];

endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage (operand select, ALU, cc, condition, M register); mulq via EXECUTE_MUL_EN.
// e_* outputs are combinational; M register and cc update one cycle later.
// No backpressure; M_bubble replaces the next M contents with a nop.
module execute_stage
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  execute_stage_if.slave ex
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_fn;
  logic [63:0] alu_res;
  logic        alu_zf;
  logic        alu_sf;
  logic        alu_of;
  logic        alu_ok;

  logic        op_bad;
  logic        set_cc;
  logic        cnd;
  logic [3:0]  dst_e;
  logic        lt;

  logic [2:0]  cc_q;
  logic [2:0]  cc_d;
  m_reg_t      m_q;
  m_reg_t      m_d;

  // Select ALU operands by instruction class
  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    case (ex.E_icode)
      I_CMOVXX, I_OPQ:            alu_a = ex.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.E_valC;
      I_CALL, I_PUSHQ:            alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:              alu_a = 64'd8;
      default:                    alu_a = 64'd0;
    endcase
    case (ex.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = ex.E_valB;
      default:                                                  alu_b = 64'd0;
    endcase
  end

  assign alu_fn = (ex.E_icode == I_OPQ) ? ex.E_ifun : ALU_ADD;

  y86_alu u_alu (
    .alu_fn (alu_fn),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of),
    .fn_ok  (alu_ok)
  );

  // An OPq with an unsupported function becomes an INS fault and never touches cc
  assign op_bad = (ex.E_icode == I_OPQ) && !alu_ok;
  assign set_cc = (ex.E_icode == I_OPQ) && alu_ok &&
                  !stat_is_exc(ex.m_stat) && !stat_is_exc(ex.W_stat);

  assign lt = cc_q[1] ^ cc_q[0];

  // Evaluate the condition against the registered flags (same-cycle OPq not yet visible)
  always_comb begin
    cnd = 1'b0;
    case (ex.E_ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | cc_q[2];
      C_L:     cnd = lt;
      C_E:     cnd = cc_q[2];
      C_NE:    cnd = !cc_q[2];
      C_GE:    cnd = !lt;
      C_G:     cnd = !lt && !cc_q[2];
      default: cnd = 1'b0;
    endcase
  end

  assign dst_e     = ((ex.E_icode == I_CMOVXX) && !cnd) ? RNONE : ex.E_dstE;
  assign ex.e_valE = op_bad ? 64'd0 : alu_res;
  assign ex.e_dstE = dst_e;
  assign ex.e_Cnd  = cnd;

  // Next flags: load fresh ALU flags only when the update is allowed
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = {alu_zf, alu_sf, alu_of};
    end
  end

  // Next M register contents: bubble or the executed instruction
  always_comb begin
    m_d = M_BUBBLE;
    if (!ex.M_bubble) begin
      m_d.stat  = op_bad ? STAT_INS : ex.E_stat;
      m_d.icode = ex.E_icode;
      m_d.cnd   = cnd;
      m_d.val_e = ex.e_valE;
      m_d.val_a = ex.E_valA;
      m_d.dst_e = dst_e;
      m_d.dst_m = ex.E_dstM;
    end
  end

  // State registers; reset forces flags and a bubble regardless of the clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
      m_q  <= M_BUBBLE;
    end else begin
      cc_q <= cc_d;
      m_q  <= m_d;
    end
  end

  assign ex.cc      = cc_q;
  assign ex.M_stat  = m_q.stat;
  assign ex.M_icode = m_q.icode;
  assign ex.M_Cnd   = m_q.cnd;
  assign ex.M_valE  = m_q.val_e;
  assign ex.M_valA  = m_q.val_a;
  assign ex.M_dstE  = m_q.dst_e;
  assign ex.M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed plus randomized checks of execute_stage against a behavioural model.
// Inputs change 1 ns after posedge; combinational outputs checked before the next edge, registers after it.
// Mul expectations follow EXECUTE_MUL_EN as compiled.
`timescale 1ns/1ps
module tb_execute_stage;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  execute_stage_if ex_if ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  // Reference state: flags {ZF,SF,OF} and the M register fields
  logic [2:0]  exp_cc;
  logic [2:0]  exp_mstat;
  logic [3:0]  exp_micode;
  logic        exp_mcnd;
  logic [63:0] exp_mvale;
  logic [63:0] exp_mvala;
  logic [3:0]  exp_mdste;
  logic [3:0]  exp_mdstm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_cc     = 3'b100;
    exp_mstat  = 3'd1;
    exp_micode = 4'h1;
    exp_mcnd   = 1'b0;
    exp_mvale  = 64'd0;
    exp_mvala  = 64'd0;
    exp_mdste  = 4'hF;
    exp_mdstm  = 4'hF;
  endtask

  function automatic logic mul_enabled();
`ifdef EXECUTE_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Is this OPq function supported by the build?
  function automatic logic ref_op_ok(input logic [3:0] fn);
    return (fn <= 4'd3) || (fn == 4'd4 && mul_enabled());
  endfunction

  // What each instruction class computes, as arithmetic on the operands
  function automatic logic [63:0] ref_val(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    case (ic)
      4'h2:       return a;
      4'h3:       return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        if (!ref_op_ok(fn)) return 64'd0;
        case (fn)
          4'd0:    return b + a;
          4'd1:    return b - a;
          4'd2:    return b & a;
          4'd3:    return b ^ a;
          default: return b * a;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  // Flags of an OPq: overflow taken as "true 65-bit result does not fit 64 signed bits"
  function automatic logic [2:0] ref_flags(input logic [3:0] fn, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] r;
    logic [64:0] w;
    logic        o;
    r = ref_val(4'h6, fn, a, b, 64'd0);
    o = 1'b0;
    if (fn == 4'd0) begin
      w = {b[63], b} + {a[63], a};
      o = w[64] ^ w[63];
    end else if (fn == 4'd1) begin
      w = {b[63], b} - {a[63], a};
      o = w[64] ^ w[63];
    end
    return {(r == 64'd0), r[63], o};
  endfunction

  function automatic logic ref_cond(input logic [3:0] fn, input logic [2:0] f);
    logic zf;
    logic less;
    zf   = f[2];
    less = (f[1] != f[0]);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return less || zf;
      4'd2:    return less;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !less;
      4'd6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [2:0] ms, input logic [2:0] ws, input logic bub);
    ex_if.E_stat   = st;
    ex_if.E_icode  = ic;
    ex_if.E_ifun   = fn;
    ex_if.E_valC   = c;
    ex_if.E_valA   = a;
    ex_if.E_valB   = b;
    ex_if.E_dstE   = de;
    ex_if.E_dstM   = dm;
    ex_if.m_stat   = ms;
    ex_if.W_stat   = ws;
    ex_if.M_bubble = bub;
  endtask

  // One pipeline cycle: check forwarding outputs, advance model, clock, check registers
  task automatic cycle();
    logic [63:0] v;
    logic        cnd;
    logic [3:0]  de;
    logic        ok;
    logic        blocked;
    #1;
    ok  = (ex_if.E_icode != 4'h6) || ref_op_ok(ex_if.E_ifun);
    v   = ref_val(ex_if.E_icode, ex_if.E_ifun, ex_if.E_valA, ex_if.E_valB, ex_if.E_valC);
    cnd = ref_cond(ex_if.E_ifun, exp_cc);
    de  = (ex_if.E_icode == 4'h2 && !cnd) ? 4'hF : ex_if.E_dstE;
    check("e_valE", ex_if.e_valE, v);
    check("e_Cnd", {63'd0, ex_if.e_Cnd}, {63'd0, cnd});
    check("e_dstE", {60'd0, ex_if.e_dstE}, {60'd0, de});
    blocked = (ex_if.m_stat inside {3'd2, 3'd3, 3'd4}) || (ex_if.W_stat inside {3'd2, 3'd3, 3'd4});
    if (ex_if.E_icode == 4'h6 && ok && !blocked)
      exp_cc = ref_flags(ex_if.E_ifun, ex_if.E_valA, ex_if.E_valB);
    if (ex_if.M_bubble) begin
      exp_mstat = 3'd1; exp_micode = 4'h1; exp_mcnd = 1'b0;
      exp_mvale = 64'd0; exp_mvala = 64'd0; exp_mdste = 4'hF; exp_mdstm = 4'hF;
    end else begin
      exp_mstat  = ok ? ex_if.E_stat : 3'd4;
      exp_micode = ex_if.E_icode;
      exp_mcnd   = cnd;
      exp_mvale  = v;
      exp_mvala  = ex_if.E_valA;
      exp_mdste  = de;
      exp_mdstm  = ex_if.E_dstM;
    end
    @(posedge clk);
    #1;
    check("M_stat", {61'd0, ex_if.M_stat}, {61'd0, exp_mstat});
    check("M_icode", {60'd0, ex_if.M_icode}, {60'd0, exp_micode});
    check("M_Cnd", {63'd0, ex_if.M_Cnd}, {63'd0, exp_mcnd});
    check("M_valE", ex_if.M_valE, exp_mvale);
    check("M_valA", ex_if.M_valA, exp_mvala);
    check("M_dstE", {60'd0, ex_if.M_dstE}, {60'd0, exp_mdste});
    check("M_dstM", {60'd0, ex_if.M_dstM}, {60'd0, exp_mdstm});
    check("cc", {61'd0, ex_if.cc}, {61'd0, exp_cc});
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [2:0] pick_stat();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
  endfunction

  initial begin
    logic [3:0] ic;
    logic [3:0] fn;
    n_assert = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b1;
    drive(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 1'b0);

    // Reset state before any clock edge
    #2;
    check("rst_cc", {61'd0, ex_if.cc}, 64'd4);
    check("rst_M_icode", {60'd0, ex_if.M_icode}, 64'd1);
    check("rst_M_stat", {61'd0, ex_if.M_stat}, 64'd1);
    check("rst_M_dstE", {60'd0, ex_if.M_dstE}, 64'hF);
    check("rst_M_dstM", {60'd0, ex_if.M_dstM}, 64'hF);
    check("rst_M_valE", ex_if.M_valE, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // addq overflow into the sign bit
    drive(3'd1, 4'h6, 4'h0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    cycle();
    check("addq_M_valE", ex_if.M_valE, 64'h8000_0000_0000_0000);
    check("addq_cc", {61'd0, ex_if.cc}, 64'h3);

    // subq equal operands -> zero, then cmovne sees ZF and suppresses its write
    drive(3'd1, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    cycle();
    check("subq_M_valE", ex_if.M_valE, 64'd0);
    check("subq_cc", {61'd0, ex_if.cc}, 64'h4);
    drive(3'd1, 4'h2, 4'h4, 64'd0, 64'h55, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 1'b0);
    #1;
    check("cmovne_e_Cnd", {63'd0, ex_if.e_Cnd}, 64'd0);
    check("cmovne_e_dstE", {60'd0, ex_if.e_dstE}, 64'hF);
    cycle();

    // OPq while memory stage reports ADR: flags frozen, M still loads
    drive(3'd1, 4'h6, 4'h3, 64'd0, 64'd1, 64'd0, 4'h4, 4'hF, 3'd3, 3'd1, 1'b0);
    cycle();
    check("adr_cc_held", {61'd0, ex_if.cc}, 64'h4);
    check("adr_M_valE", ex_if.M_valE, 64'd1);

    // Stack pointer arithmetic
    drive(3'd1, 4'hA, 4'h0, 64'd0, 64'h77, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 1'b0);
    #1;
    check("pushq_e_valE", ex_if.e_valE, 64'hF8);
    cycle();
    drive(3'd1, 4'hB, 4'h0, 64'd0, 64'h100, 64'h100, 4'h4, 4'h5, 3'd1, 3'd1, 1'b0);
    #1;
    check("popq_e_valE", ex_if.e_valE, 64'h108);
    cycle();

    // Bubble overrides an irmovq
    drive(3'd1, 4'h3, 4'h0, 64'h1234, 64'd0, 64'd0, 4'h6, 4'hF, 3'd1, 3'd1, 1'b1);
    cycle();
    check("bub_M_icode", {60'd0, ex_if.M_icode}, 64'd1);
    check("bub_M_dstE", {60'd0, ex_if.M_dstE}, 64'hF);
    check("bub_M_stat", {61'd0, ex_if.M_stat}, 64'd1);

    // Reset pulse between edges with an andq pending; edge after release acts normally
    drive(3'd1, 4'h6, 4'h0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    cycle();
    drive(3'd1, 4'h6, 4'h2, 64'd0, 64'd1, 64'd1, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("pulse_cc", {61'd0, ex_if.cc}, 64'h4);
    check("pulse_M_icode", {60'd0, ex_if.M_icode}, 64'd1);
    check("pulse_M_dstE", {60'd0, ex_if.M_dstE}, 64'hF);
    model_reset();
    #1;
    rst = 1'b0;
    cycle();
    check("post_rst_cc", {61'd0, ex_if.cc}, 64'h0);

    // mulq: product when built with the multiplier, otherwise an INS fault
    drive(3'd1, 4'h6, 4'h4, 64'd0, 64'd3, 64'd7, 4'h2, 4'hF, 3'd1, 3'd1, 1'b0);
    cycle();
`ifdef EXECUTE_MUL_EN
    check("mul_M_valE", ex_if.M_valE, 64'd21);
    check("mul_M_stat", {61'd0, ex_if.M_stat}, 64'd1);
`else
    check("mul_M_valE", ex_if.M_valE, 64'd0);
    check("mul_M_stat", {61'd0, ex_if.M_stat}, 64'd4);
    check("mul_cc_held", {61'd0, ex_if.cc}, 64'h0);
`endif

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      ic = 4'($urandom_range(0, 11));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 7));
      drive(pick_stat(), ic, fn, pick_val(), pick_val(), pick_val(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            pick_stat(), pick_stat(), ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
